// File: rtl/segment_led_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan driver.
// Sized for the widest supported display (8 digits).
package segment_led_pkg;

    localparam int MAX_DIGITS = 8;
    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [3:0] digit_of(
        input logic [4*MAX_DIGITS-1:0] v,
        input int                      i
    );
        return v[4*i +: 4];
    endfunction

endpackage

// File: rtl/segment_led_tick_gen.sv
// Digit-slot prescaler: counts 0..TICKS-1 and flags the last count.
// The flag is combinational so the scan index advances on the wrap edge.
module segment_led_tick_gen
    import segment_led_pkg::*;
#(
    parameter int TICKS = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = cnt_w(TICKS);
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/segment_led_scan_driver.sv
// Common-anode multi-digit scan controller with frame-synchronous commit
// of staged display data and leading-zero blanking.
module segment_led_scan_driver
    import segment_led_pkg::*;
#(
    parameter int DIGITS          = 4,
    parameter int TICKS_PER_DIGIT = 50000
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [4*DIGITS-1:0]   Value,
    input  logic [DIGITS-1:0]     ValidMask,
    input  logic                  Load,
    input  logic                  LeadingZeroBlank,
    input  logic                  Enable,
    output logic                  Pending,
    output logic                  FrameDone,
    output logic [3:0]            HexDigit,
    output logic                  Undefined,
    output logic [DIGITS-1:0]     Anodes
);

    localparam int IW = cnt_w(DIGITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    logic                    tick;
    logic                    wrap;
    logic [IW-1:0]           idx;
    logic [4*DIGITS-1:0]     staged_val;
    logic [DIGITS-1:0]       staged_mask;
    logic [4*DIGITS-1:0]     shadow_val;
    logic [DIGITS-1:0]       shadow_mask;
    logic [4*MAX_DIGITS-1:0] shadow_wide;
    logic [DIGITS-1:0]       blank;
    logic [DIGITS-1:0]       sel;
    logic                    run;
    logic [3:0]              cur_hex;
    logic                    cur_valid;
    logic                    lit;

    segment_led_tick_gen #(
        .TICKS (TICKS_PER_DIGIT)
    ) u_tick (
        .clk  (Clk),
        .rst  (Rst),
        .tick (tick)
    );

    assign wrap = tick && (idx == LAST_IDX);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            idx <= '0;
        end else if (tick) begin
            idx <= wrap ? '0 : idx + 1'b1;
        end
    end

    // A load coinciding with commit lands in staging after the old data moves.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            staged_val  <= '0;
            staged_mask <= '0;
            shadow_val  <= '0;
            shadow_mask <= '0;
            Pending     <= 1'b0;
            FrameDone   <= 1'b0;
        end else begin
            FrameDone <= wrap;
            if (wrap && Pending) begin
                shadow_val  <= staged_val;
                shadow_mask <= staged_mask;
                Pending     <= 1'b0;
            end
            if (Load) begin
                staged_val  <= Value;
                staged_mask <= ValidMask;
                Pending     <= 1'b1;
            end
        end
    end

    // Blank from the top down while digits are valid zeros; digit 0 never.
    always_comb begin
        shadow_wide = '0;
        shadow_wide[4*DIGITS-1:0] = shadow_val;
        blank = '0;
        run   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            run = run
                && (digit_of(shadow_wide, i) == 4'h0)
                && shadow_mask[i];
            blank[i] = run;
        end
    end

    always_comb begin
        cur_hex   = digit_of(shadow_wide, int'(idx));
        cur_valid = shadow_mask[idx];
        sel       = '0;
        sel[idx]  = 1'b1;
        lit       = Enable && !(LeadingZeroBlank && blank[idx]);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            HexDigit  <= 4'h0;
            Undefined <= 1'b1;
            Anodes    <= ANODE_OFF[DIGITS-1:0];
        end else begin
            HexDigit  <= cur_hex;
            Undefined <= ~cur_valid;
            Anodes    <= lit ? ~sel : ANODE_OFF[DIGITS-1:0];
        end
    end

endmodule

// File: tb/tb_segment_led_scan_driver.sv
// Self-checking bench for segment_led_scan_driver (4 digits, 4 ticks).
// Cycle-level reference model derived from frame arithmetic.
module tb_segment_led_scan_driver;

    localparam int D  = 4;
    localparam int T  = 4;
    localparam int FR = D * T;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [15:0] Value;
    logic [3:0]  Mask;
    logic        Load;
    logic        LZB;
    logic        En;
    logic        Pending;
    logic        FrameDone;
    logic [3:0]  HexDigit;
    logic        Undefined;
    logic [3:0]  Anodes;

    segment_led_scan_driver #(
        .DIGITS          (D),
        .TICKS_PER_DIGIT (T)
    ) dut (
        .Clk              (Clk),
        .Rst              (Rst),
        .Value            (Value),
        .ValidMask        (Mask),
        .Load             (Load),
        .LeadingZeroBlank (LZB),
        .Enable           (En),
        .Pending          (Pending),
        .FrameDone        (FrameDone),
        .HexDigit         (HexDigit),
        .Undefined        (Undefined),
        .Anodes           (Anodes)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_stv, m_shv;
    logic [3:0]  m_stm, m_shm;
    logic        m_pend, m_fd, m_und;
    logic [3:0]  m_hex, m_an;
    int          cyc;
    int          out_idx;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic       fd;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic blanked(input int i);
        if (!LZB || i == 0) return 1'b0;
        for (int j = i; j < D; j++) begin
            if (m_shv[4*j +: 4] != 4'h0 || !m_shm[j]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_edge();
        int   idx;
        logic wrap;
        if (Rst) begin
            m_stv = '0; m_stm = '0; m_shv = '0; m_shm = '0;
            m_pend = 0; m_fd = 0;
            m_hex = 0; m_und = 1; m_an = 4'hF;
            cyc = 0; out_idx = 0;
        end else begin
            idx  = (cyc / T) % D;
            wrap = ((cyc % FR) == FR - 1);
            m_hex = m_shv[4*idx +: 4];
            m_und = ~m_shm[idx];
            m_an  = (En && !blanked(idx)) ? ~(4'b0001 << idx) : 4'hF;
            out_idx = idx;
            m_fd = wrap;
            if (wrap && m_pend) begin
                m_shv = m_stv; m_shm = m_stm; m_pend = 0;
            end
            if (Load) begin
                m_stv = Value; m_stm = Mask; m_pend = 1;
            end
            cyc++;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge Clk);
        @(negedge Clk);
        Load = 1'b0;
        check("pending", Pending, m_pend);
        check("framedone", FrameDone, m_fd);
        check("hexdigit", HexDigit, m_hex);
        check("undefined", Undefined, m_und);
        check("anodes", Anodes, m_an);
    endtask

    task automatic wait_fd();
        logic seen = 1'b0;
        for (int i = 0; i < 3 * FR && !seen; i++) begin
            step();
            seen = FrameDone;
        end
        check("fd_timeout", seen, 1);
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] m);
        Value = v; Mask = m; Load = 1'b1;
        step();
    endtask

    task automatic expect_frame(input string name, input logic [15:0] an,
                                input logic [15:0] hx, input logic [3:0] un);
        for (int i = 0; i < FR; i++) begin
            step();
            check({name, "_an"}, Anodes, an[4*out_idx +: 4]);
            check({name, "_hex"}, HexDigit, hx[4*out_idx +: 4]);
            check({name, "_und"}, Undefined, un[out_idx]);
        end
    endtask

    initial begin
        Rst = 1; Value = 0; Mask = 0; Load = 0; LZB = 0; En = 1;
        tbl[0] = '{1,  4'hE, 1'b0};
        tbl[1] = '{5,  4'hD, 1'b0};
        tbl[2] = '{9,  4'hB, 1'b0};
        tbl[3] = '{13, 4'h7, 1'b0};
        tbl[4] = '{16, 4'h7, 1'b1};
        tbl[5] = '{17, 4'hE, 1'b0};
        tbl[6] = '{32, 4'h7, 1'b1};

        repeat (3) step();
        check("rst_anodes", Anodes, 4'hF);
        check("rst_undef", Undefined, 1);
        check("rst_pending", Pending, 0);
        check("rst_hex", HexDigit, 0);

        Rst = 0;
        begin
            int n = 0;
            foreach (tbl[k]) begin
                while (n < tbl[k].cyc) begin
                    step();
                    n++;
                end
                check("scan_an", Anodes, tbl[k].an);
                check("scan_fd", FrameDone, tbl[k].fd);
            end
        end

        repeat (5) step();
        load(16'h12AF, 4'hF);
        check("commit_pend", Pending, 1);
        wait_fd();
        check("commit_pend_clr", Pending, 0);
        expect_frame("commit", 16'h7BDE, 16'h12AF, 4'h0);

        load(16'h1111, 4'hF);
        for (int i = 0; i < FR && (cyc % FR) != FR - 1; i++) step();
        Value = 16'h2222; Mask = 4'hF; Load = 1'b1;
        step();
        check("coll_fd", FrameDone, 1);
        check("coll_pend", Pending, 1);
        step();
        check("coll_hex_old", HexDigit, 4'h1);
        wait_fd();
        check("coll_pend_clr", Pending, 0);
        step();
        check("coll_hex_new", HexDigit, 4'h2);

        LZB = 1;
        load(16'h0030, 4'hF);
        wait_fd();
        expect_frame("blank", 16'hFFDE, 16'h0030, 4'h0);
        load(16'h0030, 4'b0111);
        wait_fd();
        expect_frame("dash", 16'h7BDE, 16'h0030, 4'b1000);

        En = 0;
        wait_fd();
        for (int i = 0; i < FR; i++) begin
            step();
            check("dis_an", Anodes, 4'hF);
        end
        wait_fd();
        En = 1;
        repeat (6) step();
        load(16'h4567, 4'hF);
        step();
        Rst = 1;
        step();
        check("mrst_pend", Pending, 0);
        check("mrst_an", Anodes, 4'hF);
        Rst = 0;
        step();
        check("mrst_hex", HexDigit, 0);
        check("mrst_und", Undefined, 1);
        check("mrst_an0", Anodes, 4'hE);
        repeat (2 * FR) step();

        for (int i = 0; i < 1500; i++) begin
            Rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 49) == 0) LZB = ~LZB;
            if ($urandom_range(0, 59) == 0) En = ~En;
            if ($urandom_range(0, 11) == 0) begin
                for (int k = 0; k < D; k++) begin
                    Value[4*k +: 4] = $urandom_range(0, 1) ? 4'h0
                                    : 4'($urandom);
                    Mask[k] = ($urandom_range(0, 5) != 0);
                end
                Load = 1'b1;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
